para_serial_ctrl: RTL and testbench

Sequencer for the 8-lane parallel-to-serial shifter on the NTT output path. It accepts one 8-coefficient block from the butterfly stage via a valid/ready handshake and drives the shifter's `enable`: low to parallel-load, high for exactly 8 shift cycles. It emits per-word valid, lane index and block-boundary markers aligned to the serial word, and counts blocks to flag the end of a polynomial frame.

---
 rtl/para_serial_ctrl.sv | 148 ++++++++++++++
 tb/tb_para_serial_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/para_serial_ctrl.sv
// rtl/para_serial_ctrl.sv - load/shift sequencer and word markers for the 8-lane NTT output shifter
// Optional post-block idle gap is built when PARA_SERIAL_CTRL_GAP_EN is defined.
module para_serial_ctrl #(
  parameter int  LANES      = 8,
  parameter int  BLOCKS     = 32,
  parameter int  GAP_CYCLES = 2,
  localparam int BW         = $clog2(BLOCKS)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          shift_en,
  output logic          ser_valid,
  output logic [2:0]    ser_idx,
  output logic          ser_first,
  output logic          ser_last,
  output logic [BW-1:0] blk_idx,
  output logic          frame_done,
  output logic          busy
);

  if (LANES != 8 || BLOCKS < 2 || (BLOCKS & (BLOCKS - 1)) != 0 ||
      GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_param_check
    $error("para_serial_ctrl: unsupported parameter set");
  end

`ifdef PARA_SERIAL_CTRL_GAP_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2} state_t;
  logic [3:0]    r_gap_cnt;
  logic [3:0]    w_gap_cnt_nxt;
`else
  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;
`endif

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_word_cnt;
  logic [2:0]    w_word_cnt_nxt;

  logic          r_shift_en;
  logic [2:0]    r_ser_idx;
  logic          r_ser_first;
  logic          r_ser_last;
  logic [BW-1:0] r_blk_idx;
  logic          r_frame_done;
  logic          r_busy;

  logic          w_shift_nxt;
  logic [2:0]    w_idx_nxt;
  logic          w_first_nxt;
  logic          w_last_nxt;
  logic [BW-1:0] w_blk_nxt;
  logic          w_frame_done_nxt;
  logic          w_busy_nxt;

  assign in_ready = (r_state == S_IDLE);

  // Outputs are registered from the next state so they line up with the SHIFT cycle they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_word_cnt   <= 3'd0;
`ifdef PARA_SERIAL_CTRL_GAP_EN
      r_gap_cnt    <= 4'd0;
`endif
      r_shift_en   <= 1'b0;
      r_ser_idx    <= 3'd0;
      r_ser_first  <= 1'b0;
      r_ser_last   <= 1'b0;
      r_blk_idx    <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
`ifdef PARA_SERIAL_CTRL_GAP_EN
      r_gap_cnt    <= w_gap_cnt_nxt;
`endif
      r_shift_en   <= w_shift_nxt;
      r_ser_idx    <= w_idx_nxt;
      r_ser_first  <= w_first_nxt;
      r_ser_last   <= w_last_nxt;
      r_blk_idx    <= w_blk_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_word_cnt_nxt = r_word_cnt;
`ifdef PARA_SERIAL_CTRL_GAP_EN
    w_gap_cnt_nxt  = r_gap_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          w_state_nxt    = S_SHIFT;
          w_word_cnt_nxt = 3'(LANES - 1);
        end
      end
      S_SHIFT: begin
        w_word_cnt_nxt = r_word_cnt - 3'd1;
        if (r_word_cnt == 3'd0) begin
`ifdef PARA_SERIAL_CTRL_GAP_EN
          if (GAP_CYCLES > 0) begin
            w_state_nxt   = S_GAP;
            w_gap_cnt_nxt = 4'(GAP_CYCLES - 1);
          end else begin
            w_state_nxt   = S_IDLE;
          end
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef PARA_SERIAL_CTRL_GAP_EN
      S_GAP: begin
        w_gap_cnt_nxt = r_gap_cnt - 4'd1;
        if (r_gap_cnt == 4'd0) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Block index advances the cycle after the last word; frame_done rides on that last word.
  always_comb begin
    w_shift_nxt      = (w_state_nxt == S_SHIFT);
    w_idx_nxt        = w_shift_nxt ? w_word_cnt_nxt : 3'd0;
    w_first_nxt      = w_shift_nxt && (w_word_cnt_nxt == 3'(LANES - 1));
    w_last_nxt       = w_shift_nxt && (w_word_cnt_nxt == 3'd0);
    w_blk_nxt        = r_ser_last ? (r_blk_idx + BW'(1)) : r_blk_idx;
    w_frame_done_nxt = w_last_nxt && (r_blk_idx == BW'(BLOCKS - 1));
    w_busy_nxt       = (w_state_nxt != S_IDLE);
  end

  assign shift_en   = r_shift_en;
  assign ser_valid  = r_shift_en;
  assign ser_idx    = r_ser_idx;
  assign ser_first  = r_ser_first;
  assign ser_last   = r_ser_last;
  assign blk_idx    = r_blk_idx;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_para_serial_ctrl.sv
// tb/tb_para_serial_ctrl.sv - scoreboard bench for para_serial_ctrl with a falling-edge shifter model
// Gap expectations follow PARA_SERIAL_CTRL_GAP_EN.
module tb_para_serial_ctrl;
  localparam int BLOCKS = 4;
  localparam int GAP    = 2;
`ifdef PARA_SERIAL_CTRL_GAP_EN
  localparam int GAP_EFF = GAP;
`else
  localparam int GAP_EFF = 0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, shift_en, ser_valid, ser_first, ser_last, frame_done, busy;
  logic [2:0] ser_idx;
  logic [1:0] blk_idx;

  para_serial_ctrl #(.LANES(8), .BLOCKS(BLOCKS), .GAP_CYCLES(GAP)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .shift_en(shift_en), .ser_valid(ser_valid), .ser_idx(ser_idx), .ser_first(ser_first),
    .ser_last(ser_last), .blk_idx(blk_idx), .frame_done(frame_done), .busy(busy)
  );

  typedef struct {
    logic [7:0] word;
    int         idx;
    bit         first;
    bit         last;
    int         blk;
    bit         fd;
    int         cyc;
  } exp_t;

  logic [7:0] lanes [8];
  logic [7:0] sh    [8];
  exp_t       sb[$];
  int         hs_cyc[$];
  int         gaps[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         fd_count = 0;
  int         blk_model = 0;
  int         low_run = 0;
  bit         seen_valid = 0;
  logic [7:0] mon_word;
  exp_t       mon_e;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Shifter model and scoreboard: load/shift on the falling edge, consumer view of cycle k.
  always @(negedge clock) begin
    if (!reset_n) begin
      sb.delete();
      blk_model  = 0;
      seen_valid = 0;
      low_run    = 0;
    end else begin
      if (in_valid && in_ready) begin
        hs_cyc.push_back(cyc);
        for (int i = 7; i >= 0; i--)
          sb.push_back('{word: lanes[i], idx: i, first: (i == 7), last: (i == 0),
                         blk: blk_model, fd: (i == 0 && blk_model == BLOCKS - 1), cyc: cyc + 8 - i});
        blk_model = (blk_model + 1) % BLOCKS;
      end
      mon_word = 'x;
      if (shift_en) begin
        mon_word = sh[7];
        for (int i = 7; i > 0; i--) sh[i] = sh[i-1];
        sh[0] = '0;
      end else begin
        for (int i = 0; i < 8; i++) sh[i] = lanes[i];
      end
      if (ser_valid) begin
        if (sb.size() == 0) chk("unexpected_word", 0, 1);
        else begin
          mon_e = sb.pop_front();
          chk("word", mon_word, mon_e.word);
          chk("ser_idx", ser_idx, mon_e.idx);
          chk("ser_first", ser_first, mon_e.first);
          chk("ser_last", ser_last, mon_e.last);
          chk("blk_idx", blk_idx, mon_e.blk);
          chk("frame_done", frame_done, mon_e.fd);
          chk("word_cycle", cyc, mon_e.cyc);
        end
        if (seen_valid && low_run > 0) gaps.push_back(low_run);
        low_run    = 0;
        seen_valid = 1;
      end else begin
        chk("idle_idx", ser_idx, 0);
        chk("idle_marks", {ser_first, ser_last, frame_done}, 0);
        low_run++;
      end
      chk("shift_vs_valid", shift_en, ser_valid);
      chk("busy_vs_ready", busy, !in_ready);
      if (frame_done) fd_count++;
    end
  end

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 80; n++) begin
      @(posedge clock); #1;
      if (in_ready && sb.size() == 0) break;
    end
    chk(tag, (in_ready && sb.size() == 0), 1);
  endtask

  task automatic stream(input int nblk, input string tag);
    int seen;
    seen = 0;
    hs_cyc.delete();
    gaps.delete();
    in_valid = 1'b1;
    for (int n = 0; n < nblk * 30 && hs_cyc.size() < nblk; n++) begin
      @(posedge clock); #1;
      if (hs_cyc.size() > seen) begin
        seen = hs_cyc.size();
        for (int i = 0; i < 8; i++) lanes[i] = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    chk(tag, hs_cyc.size(), nblk);
    wait_idle({tag, "_drain"});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_shift_en"}, shift_en, 0);
    chk({tag, "_ser_valid"}, ser_valid, 0);
    chk({tag, "_ser_idx"}, ser_idx, 0);
    chk({tag, "_first_last"}, {ser_first, ser_last}, 0);
    chk({tag, "_blk_idx"}, blk_idx, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int fd_before;
    bit found;
    for (int i = 0; i < 8; i++) lanes[i] = 8'(10 + i);

    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_reset_ready", in_ready, 1);

    // Single block, lanes 10..17 emitted as 17..10 starting at H+1.
    stream(1, "single_hs");
    chk("single_blk_next", blk_idx, 1);

    // Back-to-back: handshake spacing and idle run between blocks.
    stream(3, "b2b_hs");
    if (hs_cyc.size() == 3) begin
      chk("b2b_spacing_1", hs_cyc[1] - hs_cyc[0], 9 + GAP_EFF);
      chk("b2b_spacing_2", hs_cyc[2] - hs_cyc[1], 9 + GAP_EFF);
    end
    chk("b2b_gap_records", gaps.size() >= 2, 1);
    if (gaps.size() >= 2) begin
      chk("b2b_low_run_1", gaps[gaps.size()-2], 1 + GAP_EFF);
      chk("b2b_low_run_2", gaps[gaps.size()-1], 1 + GAP_EFF);
    end
    chk("b2b_blk_wrapped", blk_idx, 0);

    // Frame wrap: five blocks from index 0 give exactly one frame_done.
    fd_before = fd_count;
    stream(5, "frame_hs");
    chk("frame_done_count", fd_count - fd_before, 1);
    chk("frame_blk_after", blk_idx, 1);

    // Reset in the middle of a block.
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clock); #1;
      if (ser_valid && ser_idx == 3'd3) begin found = 1; break; end
    end
    chk("midrst_reach_word3", found, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("midrst_release_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) lanes[i] = 8'(100 + i);
    stream(1, "midrst_fresh_hs");

    // in_valid during SHIFT is ignored; idle with in_valid low stays quiet.
    hs_cyc.delete();
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_idle("pulse_drain");
    for (int n = 0; n < 20; n++) begin
      @(posedge clock); #1;
      chk("idle_quiet", {shift_en, ser_valid}, 0);
    end
    chk("pulse_ignored", hs_cyc.size(), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
